if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage for the `RISCV_PIPELINED` core. It sits directly upstream of decode and owns the fetch PC. It issues requests to a variable-latency instruction memory with at most one request outstanding, and loads the IF/ID pipeline register. It also absorbs decode stalls and branch/jump redirects from later stages.

## Interface
- `XLEN`, 32, datapath/address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `imem_req` out 1: request strobe; memory accepts the request in the same cycle
- `imem_addr` out XLEN: word-aligned fetch address, valid when `imem_req`=1
- `imem_rvalid` in 1: response valid; at least 1 cycle after the request, one per request
- `imem_rdata` in 32: instruction word
- `stall_id` in 1: decode cannot accept; IF/ID holds its value
- `redirect_valid` in 1: flush and restart fetch at `redirect_pc`
- `redirect_pc` in XLEN: redirect target
- `if_id_valid` out 1: IF/ID holds a live instruction
- `if_id_pc` out XLEN: PC of the IF/ID instruction
- `if_id_pc_plus4` out XLEN: `if_id_pc`+4
- `if_id_instr` out 32: instruction, or NOP (32'h0000_0013) when not valid

## Operation
- State machine:
  - IDLE: entered on reset.
  - FETCH: issue a request at `fetch_pc`.
  - WAIT: one request outstanding.
  - HOLD: a response is buffered because decode is stalled.
- Transitions:
  - IDLE→FETCH: unconditionally, one cycle after reset deasserts.
  - FETCH→WAIT: request issued.
  - WAIT, `rvalid`=1, `kill`=0, `stall_id`=0:
    - load IF/ID;
    - `fetch_pc` += 4;
    - issue the next request the same cycle at the new `fetch_pc`;
    - stay in WAIT.
  - WAIT, `rvalid`=1, `kill`=0, `stall_id`=1:
    - write the response into the hold buffer;
    - `fetch_pc` += 4;
    - go to HOLD.
  - WAIT, `rvalid`=1, `kill`=1: drop the response, clear `kill`, go to FETCH.
  - HOLD, `stall_id`=0: move the buffer into IF/ID, go to FETCH.
- Request strobe: `imem_req` = (FETCH or WAIT-with-load) and not `redirect_valid`.
- Redirect has highest priority in every state, and flush wins over stall:
  - `fetch_pc` ← `redirect_pc`;
  - `if_id_valid` ← 0 and `if_id_instr` ← NOP;
  - hold buffer discarded.
- Redirect effect by state:
  - WAIT with no response this cycle: set `kill`, stay in WAIT.
  - WAIT with a response the same cycle, HOLD, or FETCH: go to FETCH (no request that cycle).
  - IDLE: `fetch_pc` is loaded with `redirect_pc`; the FSM still advances to FETCH.
- Decode stall: `stall_id`=1 with no redirect leaves all IF/ID fields unchanged.
- Arithmetic: PC adds are modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0.
- Alignment: `redirect_pc[1:0]` is ignored, and `imem_addr[1:0]` is always 0.
- An `imem_rvalid` arriving outside WAIT is ignored.

## Timing
- Reset values:
  - `imem_req`=0;
  - `if_id_valid`=0;
  - `if_id_pc`=0 and `if_id_pc_plus4`=4;
  - `if_id_instr`=32'h0000_0013;
  - `fetch_pc`=`RESET_PC`;
  - `kill`=0; hold buffer empty.
- Asserting `reset` mid-operation aborts any outstanding request; a late `rvalid` is ignored because the FSM is not in WAIT.
- First request: the cycle after `reset` falls.
- Latency: request cycle N, memory latency L → IF/ID valid after the edge ending cycle N+L.
- Throughput: one instruction per cycle when L=1 and there is no stall.
- Redirect in cycle N: the IF/ID bubble is visible after that edge; the new request goes out in cycle N+1.
- All outputs are registered except `imem_req` and `imem_addr`.

## Configuration
- Macro: `IF_PERF_CNT_EN`.
- Defined: adds outputs `perf_fetch_cnt[31:0]` and `perf_stall_cnt[31:0]`. Both reset to 0 and wrap.
  - `perf_fetch_cnt` increments per instruction loaded into IF/ID.
  - `perf_stall_cnt` increments per cycle with `stall_id`=1 and `if_id_valid`=1.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `if_pkg`:
  - `NOP_INSTR`;
  - `if_state_e` (IDLE/FETCH/WAIT/HOLD);
  - `if_id_t` struct (`valid`, `pc`, `pc_plus4`, `instr`).
- One natural sub-module: `if_hold_buf`, a one-entry buffer with load/drain/flush.

## Test plan
- Reset release, memory L=1, no stall:
  - `imem_addr` sequence 0,4,8,12 on consecutive cycles;
  - IF/ID `pc` 0,4,8 with `valid`=1 each cycle from the third cycle after release.
- `stall_id` held 3 cycles while an instruction at PC 0x10 is in IF/ID:
  - IF/ID holds 0x10 throughout;
  - the buffered 0x14 appears the cycle after release;
  - no response is lost.
- `redirect_valid` with `redirect_pc`=0x200 while WAIT and L=3, response arriving 2 cycles later:
  - the stale response is dropped;
  - next `imem_addr`=0x200;
  - IF/ID shows `valid`=0 until the 0x200 instruction arrives.
- Redirect and `stall_id` in the same cycle:
  - `if_id_valid`=0 and `if_id_instr`=32'h0000_0013 after the edge.
- `redirect_pc`=32'hFFFF_FFFE:
  - fetches 0xFFFF_FFFC, then 0x0000_0000.
- With `IF_PERF_CNT_EN`:
  - 10 fetches plus 4 stall cycles → `perf_fetch_cnt`=10, `perf_stall_cnt`=4;
  - reset mid-run → both counters 0.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
package if_pkg;

   // Width of the PC fields carried in if_id_t. The top-level XLEN must match it.
   localparam int          IF_XLEN   = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } if_state_e;

   typedef struct packed {
      logic               valid;
      logic [IF_XLEN-1:0] pc;
      logic [IF_XLEN-1:0] pc_plus4;
      logic [31:0]        instr;
   } if_id_t;

endpackage

// File: rtl/if_hold_buf.sv
// if_hold_buf: one-entry buffer that parks a fetch response while decode is stalled.
module if_hold_buf
   import if_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   load,
   input  logic   drain,
   input  logic   flush,
   input  if_id_t din,
   output logic   valid,
   output if_id_t dout
);

   // Occupancy: reset, flush and drain empty the entry; load fills it.
   always_ff @(posedge clk) begin
      if (reset || flush || drain) valid <= 1'b0;
      else if (load)               valid <= 1'b1;
   end

   // Payload is only captured; occupancy qualifies it, so no reset is needed.
   always_ff @(posedge clk) begin
      if (load) dout <= din;
   end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the fetch PC, keeps at most one imem request in flight
// and loads the IF/ID register. Handles decode stalls and redirects.
// Optional feature: define IF_PERF_CNT_EN to add fetch/stall performance counters.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter int              XLEN     = IF_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   input  logic            stall_id,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
`ifdef IF_PERF_CNT_EN
   output logic [31:0]     perf_fetch_cnt,
   output logic [31:0]     perf_stall_cnt,
`endif
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic [31:0]     if_id_instr
);

   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

   if_state_e       state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] fetch_pc_next;
   logic [XLEN-1:0] redirect_tgt;
   logic            kill;
   if_id_t          if_id_p1;
   if_id_t          resp_entry;
   if_id_t          hold_entry;
   logic            hold_valid;
   logic            resp_live;
   logic            resp_load;
   logic            resp_buffer;
   logic            hold_drain;
   logic            if_id_load;

   // A response is live only in WAIT and only if no earlier redirect killed it.
   assign fetch_pc_next = fetch_pc + PC_STEP;
   assign redirect_tgt  = redirect_pc & ALIGN_MASK;
   assign resp_live     = (state == WAIT) && imem_rvalid && !kill;
   assign resp_load     = resp_live && !stall_id;
   assign resp_buffer   = resp_live && stall_id;
   assign hold_drain    = (state == HOLD) && hold_valid && !stall_id;
   assign if_id_load    = !redirect_valid && (resp_load || hold_drain);

   // Back-to-back issue: on a loading response the next request uses the incremented PC.
   assign imem_req   = ((state == FETCH) || resp_load) && !redirect_valid;
   assign imem_addr  = (resp_load ? fetch_pc_next : fetch_pc) & ALIGN_MASK;
   assign resp_entry = '{valid: 1'b1, pc: fetch_pc, pc_plus4: fetch_pc_next, instr: imem_rdata};

   if_hold_buf u_hold_buf (
      .clk   (clk),
      .reset (reset),
      .load  (resp_buffer && !redirect_valid),
      .drain (hold_drain && !redirect_valid),
      .flush (redirect_valid),
      .din   (resp_entry),
      .valid (hold_valid),
      .dout  (hold_entry)
   );

   // Fetch control FSM: redirect overrides every state; a redirect with a request
   // still in flight arms kill so the stale response is swallowed later.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         fetch_pc <= RESET_PC & ALIGN_MASK;
         kill     <= 1'b0;
      end else if (redirect_valid) begin
         fetch_pc <= redirect_tgt;
         if ((state == WAIT) && !imem_rvalid) begin
            kill  <= 1'b1;
            state <= WAIT;
         end else begin
            kill  <= 1'b0;
            state <= FETCH;
         end
      end else begin
         case (state)
            IDLE:  state <= FETCH;
            FETCH: state <= WAIT;
            WAIT: begin
               if (imem_rvalid) begin
                  if (kill) begin
                     kill  <= 1'b0;
                     state <= FETCH;
                  end else begin
                     fetch_pc <= fetch_pc_next;
                     state    <= stall_id ? HOLD : WAIT;
                  end
               end
            end
            HOLD:    if (!stall_id) state <= FETCH;
            default: state <= IDLE;
         endcase
      end
   end

   // IF/ID register: flush beats stall, stall freezes, otherwise load or insert a bubble.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_id_p1 <= '{valid: 1'b0, pc: '0, pc_plus4: PC_STEP, instr: NOP_INSTR};
      end else if (redirect_valid) begin
         if_id_p1.valid <= 1'b0;
         if_id_p1.instr <= NOP_INSTR;
      end else if (stall_id) begin
         if_id_p1 <= if_id_p1;
      end else if (resp_load) begin
         if_id_p1 <= resp_entry;
      end else if (hold_drain) begin
         if_id_p1 <= hold_entry;
      end else begin
         if_id_p1.valid <= 1'b0;
         if_id_p1.instr <= NOP_INSTR;
      end
   end

   assign if_id_valid    = if_id_p1.valid;
   assign if_id_pc       = if_id_p1.pc;
   assign if_id_pc_plus4 = if_id_p1.pc_plus4;
   assign if_id_instr    = if_id_p1.instr;

`ifdef IF_PERF_CNT_EN
   // Free-running wrap-around counters of delivered instructions and stalled live cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (if_id_load)              perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         if (stall_id && if_id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and randomized bench for if_fetch_stage with a
// variable-latency memory model and a program-order reference model.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        stall_id;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   always #5 clk = ~clk;

   if_fetch_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .stall_id       (stall_id),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
`ifdef IF_PERF_CNT_EN
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_instr    (if_id_instr)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // stimulus controls
   logic        rst_cmd, stall_cmd, redir_cmd;
   logic [31:0] redir_tgt;
   int          lat_fixed;

   // memory model
   logic        pend;
   logic [31:0] pend_addr;
   int          pend_cnt;

   // reference model
   logic [31:0] exp_pc, exp_req_pc;
   logic        e_valid;
   logic [31:0] e_pc, e_pc4, e_instr;
   int          delivered;
   logic [31:0] exp_pf, exp_ps;

   // last-step observations
   logic        req_s;
   logic [31:0] addr_s;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'h1234_5677;
   endfunction

   function automatic int pick_lat();
      if (lat_fixed > 0) return lat_fixed;
      return int'($urandom_range(1, 4));
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, then check IF/ID after posedge.
   task automatic step();
      logic [96:0] post;
      @(negedge clk);
      reset          = rst_cmd;
      stall_id       = stall_cmd;
      redirect_valid = redir_cmd;
      redirect_pc    = redir_tgt;
      imem_rvalid    = 1'b0;
      imem_rdata     = 32'h0;
      if (pend) begin
         pend_cnt--;
         if (pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(pend_addr);
         end
      end
      #1;
      req_s  = imem_req;
      addr_s = imem_addr;
      if (!reset) begin
         if (redirect_valid) chk("req_on_redirect", 128'(imem_req), 128'(1'b0));
         if (req_s) begin
            chk("req_addr", 128'(addr_s), 128'(exp_req_pc));
            chk("one_outstanding", 128'(pend && !imem_rvalid), 128'(1'b0));
         end
      end
      @(posedge clk);
      #1;
      post = {if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr};
      if (reset) begin
         e_valid = 1'b0; e_pc = 32'h0; e_pc4 = 32'h4; e_instr = NOP;
         chk("reset_ifid", 128'(post), 128'({e_valid, e_pc, e_pc4, e_instr}));
         exp_pc = RESET_PC; exp_req_pc = RESET_PC;
         exp_pf = 0; exp_ps = 0; pend = 1'b0;
      end else begin
         if (imem_rvalid) pend = 1'b0;
         if (req_s) begin
            pend = 1'b1; pend_addr = addr_s; pend_cnt = pick_lat();
            exp_req_pc = exp_req_pc + 32'd4;
         end
         if (stall_id && e_valid) exp_ps++;
         if (redirect_valid) begin
            exp_pc = redirect_pc & ~32'd3;
            exp_req_pc = exp_pc;
            e_valid = 1'b0; e_instr = NOP;
            chk("redirect_flush", 128'({if_id_valid, if_id_instr}), 128'({1'b0, NOP}));
         end else if (stall_id) begin
            chk("stall_hold", 128'(post), 128'({e_valid, e_pc, e_pc4, e_instr}));
         end else if (if_id_valid) begin
            e_valid = 1'b1; e_pc = exp_pc; e_pc4 = exp_pc + 32'd4; e_instr = memf(exp_pc);
            chk("ifid_load", 128'(post), 128'({e_valid, e_pc, e_pc4, e_instr}));
            exp_pc = exp_pc + 32'd4;
            delivered++; exp_pf++;
         end else begin
            e_valid = 1'b0; e_instr = NOP;
            chk("ifid_bubble", 128'(if_id_instr), 128'(NOP));
         end
      end
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch", 128'(perf_fetch_cnt), 128'(exp_pf));
      chk("perf_stall", 128'(perf_stall_cnt), 128'(exp_ps));
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic found;
      logic seen;
      int   nreq;
      int   base;
      reset = 1'b1; stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
      imem_rvalid = 1'b0; imem_rdata = 32'h0;
      rst_cmd = 1'b1; stall_cmd = 1'b0; redir_cmd = 1'b0; redir_tgt = 32'h0; lat_fixed = 1;
      pend = 1'b0; pend_addr = 32'h0; pend_cnt = 0;
      exp_pc = RESET_PC; exp_req_pc = RESET_PC; delivered = 0; exp_pf = 0; exp_ps = 0;
      e_valid = 1'b0; e_pc = 32'h0; e_pc4 = 32'h4; e_instr = NOP;

      step();
      step();
      chk("rst_req", 128'(req_s), 128'(1'b0));
      rst_cmd = 1'b0;

      // reset release, L=1, no stall
      for (int k = 0; k < 5; k++) begin
         step();
         if (k == 0) chk("t1_idle_req", 128'(req_s), 128'(1'b0));
         if (k >= 1) chk("t1_req", 128'({req_s, addr_s}), 128'({1'b1, 32'(4 * (k - 1))}));
         if (k >= 2) chk("t1_ifid", 128'({if_id_valid, if_id_pc}), 128'({1'b1, 32'(4 * (k - 2))}));
      end

      // stall for three cycles with 0x10 in IF/ID
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (if_id_valid && if_id_pc == 32'h10) found = 1'b1;
      end
      chk("t2_reach_0x10", 128'(found), 128'(1'b1));
      stall_cmd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_hold", 128'({if_id_valid, if_id_pc}), 128'({1'b1, 32'h10}));
      end
      stall_cmd = 1'b0;
      step();
      chk("t2_release", 128'({if_id_valid, if_id_pc, if_id_instr}), 128'({1'b1, 32'h14, memf(32'h14)}));
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (if_id_valid) begin
            chk("t2_next", 128'(if_id_pc), 128'(32'h18));
            found = 1'b1;
         end
      end
      chk("t2_next_seen", 128'(found), 128'(1'b1));

      // redirect to 0x200 while WAIT, L=3, stale response two cycles later
      lat_fixed = 3;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (req_s) found = 1'b1;
      end
      chk("t3_req_seen", 128'(found), 128'(1'b1));
      redir_cmd = 1'b1; redir_tgt = 32'h200;
      step();
      chk("t3_bubble", 128'({if_id_valid, if_id_instr}), 128'({1'b0, NOP}));
      redir_cmd = 1'b0;
      found = 1'b0; seen = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (req_s && !seen) begin
            chk("t3_addr", 128'(addr_s), 128'(32'h200));
            seen = 1'b1;
         end
         if (if_id_valid) begin
            chk("t3_first", 128'({seen, if_id_pc}), 128'({1'b1, 32'h200}));
            found = 1'b1;
         end
      end
      chk("t3_arrived", 128'(found), 128'(1'b1));

      // redirect and stall in the same cycle
      lat_fixed = 1;
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         step();
         if (if_id_valid) found = 1'b1;
      end
      chk("t4_valid_seen", 128'(found), 128'(1'b1));
      stall_cmd = 1'b1; redir_cmd = 1'b1; redir_tgt = 32'h300;
      step();
      chk("t4_flush", 128'({if_id_valid, if_id_instr}), 128'({1'b0, NOP}));
      stall_cmd = 1'b0; redir_cmd = 1'b0;

      // misaligned redirect near the top of the address space wraps
      redir_cmd = 1'b1; redir_tgt = 32'hFFFF_FFFE;
      step();
      redir_cmd = 1'b0;
      nreq = 0; found = 1'b0;
      for (int i = 0; i < 20 && !(found && nreq >= 2); i++) begin
         step();
         if (req_s) begin
            if (nreq == 0) chk("t5_addr0", 128'(addr_s), 128'(32'hFFFF_FFFC));
            if (nreq == 1) chk("t5_addr1", 128'(addr_s), 128'(32'h0));
            nreq++;
         end
         if (if_id_valid && !found) begin
            chk("t5_wrap", 128'({if_id_pc, if_id_pc_plus4}), 128'({32'hFFFF_FFFC, 32'h0}));
            found = 1'b1;
         end
      end
      chk("t5_done", 128'({found, nreq >= 2}), 128'({1'b1, 1'b1}));

`ifdef IF_PERF_CNT_EN
      // ten fetches with four stalled live cycles, then reset mid-run
      rst_cmd = 1'b1; step(); rst_cmd = 1'b0;
      nreq = 0;
      for (int i = 0; i < 60 && exp_pf < 10; i++) begin
         stall_cmd = (exp_pf == 3 && nreq < 4);
         if (stall_cmd) nreq++;
         step();
      end
      stall_cmd = 1'b0;
      chk("perf_counts", 128'({perf_fetch_cnt, perf_stall_cnt}), 128'({32'd10, 32'd4}));
      step(); step();
      rst_cmd = 1'b1; step(); rst_cmd = 1'b0;
      chk("perf_reset", 128'({perf_fetch_cnt, perf_stall_cnt}), 128'(64'h0));
`endif

      // randomized traffic
      lat_fixed = 0;
      base = delivered;
      for (int i = 0; i < 3000; i++) begin
         stall_cmd = ($urandom_range(0, 99) < 25);
         redir_cmd = ($urandom_range(0, 99) < 4);
         redir_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
         rst_cmd   = ($urandom_range(0, 999) < 3);
         step();
      end
      rst_cmd = 1'b0; stall_cmd = 1'b0; redir_cmd = 1'b0;
      chk("liveness", 128'(delivered - base > 200), 128'(1'b1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
